router_input_fifo: RTL
======================

Name: router_input_fifo

Overview:
- Per-port input buffer for the NoC router. One instance per port: north, south, east, west and local.
- Sits between the link input (`north_i` etc. and `n_iner_o` etc.) and the router's route/arbitration stage.
- Stores incoming 16-bit flits in order and presents the head flit to the router core.
- Drives link-level backpressure and reports occupancy and overflow status.

Parameters:
- WIDTH, 16, flit width in bits.
- DEPTH, 4, number of flit entries. Legal range 2..16; need not be a power of two.
- AF_THRESH, 3, occupancy at or above which almost_full_o asserts. Legal range 1..DEPTH.

Ports:
- clk  input  1  router clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Clears all state while low.
- flit_i  input  WIDTH  flit from the upstream link.
- flit_valid_i  input  1  flit_i carries a valid flit this cycle.
- iner_o  output  1  space available to upstream; 1 = a flit can be accepted this cycle.
- flit_o  output  WIDTH  head flit presented to the router core.
- flit_valid_o  output  1  flit_o is valid.
- flit_pop_i  input  1  router core consumes the head flit this cycle.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full_o  output  1  count_o >= AF_THRESH.
- ovf_o  output  1  sticky overflow error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - rd_ptr = 0, wr_ptr = 0, count = 0, ovf_o = 0.
  - Resulting outputs: flit_valid_o = 0, flit_o = 0, iner_o = 1, almost_full_o = 0.
  - Storage array contents are don't-care.
  - Reset asserted mid-transfer discards all stored flits immediately; no partial state survives.
- Derived signals:
  - full = (count == DEPTH); empty = (count == 0).
  - iner_o = !full | flit_pop_i. A slot freed by a same-cycle pop may be refilled.
- Push: push = flit_valid_i & (!full | flit_pop_i).
  - On a push, mem[wr_ptr] <= flit_i and wr_ptr advances.
- Pop: pop = flit_pop_i & !empty.
  - On a pop, rd_ptr advances.
  - flit_pop_i while empty is ignored: no pointer or count change, no error.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Explicit compare; no reliance on power-of-two rollover.
- Count update:
  - push only: count + 1.
  - pop only: count - 1.
  - both, or neither: unchanged.
- Read path:
  - flit_o = mem[rd_ptr] combinationally when !empty; flit_o = 0 when empty.
  - flit_valid_o = !empty.
- Latency: a flit pushed at edge N appears on flit_o and flit_valid_o after edge N. Minimum latency is 1 cycle.
- Overflow:
  - Condition: flit_valid_i & full & !flit_pop_i.
  - The flit is dropped; pointers and count are unchanged.
  - ovf_o is set at that edge and stays 1 until reset.
- Simultaneous push and pop:
  - When full: both succeed, count stays DEPTH, no overflow.
  - When empty: only the push takes effect, since the pop is ignored.
- almost_full_o and count_o are combinational from the registered count.
- Ordering: strict FIFO. Flits leave in arrival order with no reordering or duplication.

Optional Feature:
- Macro: ROUTER_FIFO_BYPASS_EN.
- Defined:
  - When empty & flit_valid_i: flit_o = flit_i and flit_valid_o = 1 in the same cycle (zero-latency fall-through).
  - If flit_pop_i is also asserted that cycle, the flit is consumed directly: not written, pointers and count unchanged.
  - If flit_pop_i is low, the flit is written normally.
  - iner_o is unaffected.
- Undefined:
  - No combinational path from flit_i or flit_valid_i to flit_o or flit_valid_o.
  - Minimum latency is 1 cycle, as specified in Behaviour.

Test Plan:
- Reset: hold rst=0 for 3 cycles with flit_valid_i=1, then release.
  -> count_o=0, flit_valid_o=0, flit_o=16'h0000, iner_o=1, ovf_o=0; no flit stored during reset.
- Fill and drain (DEPTH=4): push 16'hA001..16'hA004 back-to-back, then pop 4 times.
  -> count_o 1,2,3,4; almost_full_o=1 from count_o=3; iner_o=0 at count_o=4.
  -> pops return A001..A004 in order, then flit_valid_o=0.
- Full with simultaneous push/pop: FIFO holds A001..A004; push 16'hB005 with flit_pop_i=1.
  -> count_o stays 4, ovf_o=0; head becomes A002; B005 appears at the tail after 3 further pops.
- Overflow: FIFO full; push 16'hDEAD with flit_pop_i=0.
  -> count_o=4 unchanged, ovf_o=1 and stays 1 through 10 further idle cycles; DEAD is never output.
- Pointer wrap: 12 interleaved push/pop pairs with values 16'h0000..16'h000B.
  -> outputs emerge 0000..000B in order; count_o never exceeds 2; pointers wrap through 0 three times.
- Empty pop and bypass: flit_pop_i=1 while empty.
  -> no state change.
  - With ROUTER_FIFO_BYPASS_EN: push 16'hC0DE with pop in the same cycle -> flit_o=C0DE that cycle, count_o stays 0.
  - Without the macro: C0DE appears the next cycle with count_o=1.

Source files
------------

// File: rtl/router_input_fifo.sv
// router_input_fifo: per-port NoC input flit FIFO with link backpressure, occupancy and sticky overflow.
// Optional build macro ROUTER_FIFO_BYPASS_EN enables zero-latency fall-through while empty.
module router_input_fifo #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         flit_i,
  input  logic                     flit_valid_i,
  output logic                     iner_o,
  output logic [WIDTH-1:0]         flit_o,
  output logic                     flit_valid_o,
  input  logic                     flit_pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     almost_full_o,
  output logic                     ovf_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bypass;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
`ifdef ROUTER_FIFO_BYPASS_EN
    bypass = empty & flit_valid_i & flit_pop_i;
`else
    bypass = 1'b0;
`endif
    push = flit_valid_i & (~full | flit_pop_i) & ~bypass;
    pop  = flit_pop_i & ~empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (flit_valid_i && full && !flit_pop_i)
        ovf <= 1'b1;
    end
  end

  // Storage carries no reset; contents are only visible through rd_ptr while non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit_i;
  end

  always_comb begin
    flit_valid_o = ~empty;
    flit_o       = empty ? '0 : mem[rd_ptr];
`ifdef ROUTER_FIFO_BYPASS_EN
    if (empty && flit_valid_i) begin
      flit_o       = flit_i;
      flit_valid_o = 1'b1;
    end
`endif
  end

  assign iner_o        = ~full | flit_pop_i;
  assign count_o       = count;
  assign almost_full_o = (count >= CW'(AF_THRESH));
  assign ovf_o         = ovf;

endmodule
